// File: rtl/pipeline_front_ctrl.sv
// pipeline_front_ctrl
//   Front-end pipeline control for the 5-stage RISC-V core. Owns the PC,
//   the IF/ID register and the ID/EX control-field register, applying the
//   hazard unit's requests with a fixed priority each edge:
//   memory stall > load-use stall > branch flush > normal advance.
//   It also keeps performance counters for bubbles, flushes and cycles.
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   stall_i             load-use stall: hold IF/ID
//   noop_i              load-use bubble: zero the ID/EX control bundle
//   pcwrite_i           PC write enable during a load-use stall
//   flush_i             branch taken in ID: redirect PC, flush IF/ID
//   branch_target_i     redirect address
//   mem_stall_i         data memory busy: freeze the whole front end
//   instr_i             instruction fetched at pc_o
//   ctrl_i              decoded control bundle of the instruction in ID
//   pc_o                current fetch PC
//   if_id_instr_o       IF/ID instruction
//   if_id_pc_o          IF/ID PC
//   id_ex_ctrl_o        ID/EX control bundle
//   stall_cnt_o         edges on which a bubble was inserted
//   flush_cnt_o         honoured flushes
//   cycle_cnt_o         edges since reset
module pipeline_front_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int unsigned CTRL_W    = 8,
    parameter int unsigned CNT_W     = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              noop_i,
    input  logic              pcwrite_i,
    input  logic              flush_i,
    input  logic [31:0]       branch_target_i,
    input  logic              mem_stall_i,
    input  logic [31:0]       instr_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    output logic [31:0]       pc_o,
    output logic [31:0]       if_id_instr_o,
    output logic [31:0]       if_id_pc_o,
    output logic [CTRL_W-1:0] id_ex_ctrl_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o,
    output logic [CNT_W-1:0]  cycle_cnt_o
);

    localparam logic [31:0]      PC_STEP = 32'd4;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Action taken by the PC / IF/ID registers on this edge.
    typedef enum logic [1:0] {
        ACT_FREEZE,
        ACT_LOAD_USE,
        ACT_REDIRECT,
        ACT_ADVANCE
    } front_act_e;

    front_act_e        act;
    logic              bubble;
    logic [31:0]       pc_next;
    logic [31:0]       if_id_instr_next;
    logic [31:0]       if_id_pc_next;
    logic [CTRL_W-1:0] id_ex_ctrl_next;

    // A flush during a load-use stall is dropped: the branch operands in ID
    // are not valid yet, and the branch re-resolves once the stall clears.
    always_comb begin
        act = ACT_ADVANCE;
        if (mem_stall_i) begin
            act = ACT_FREEZE;
        end else if (stall_i) begin
            act = ACT_LOAD_USE;
        end else if (flush_i) begin
            act = ACT_REDIRECT;
        end
    end

    // noop_i zeroes ID/EX whenever the front end is not frozen, independent
    // of what the PC and IF/ID do on the same edge.
    assign bubble = noop_i && (act != ACT_FREEZE);

    always_comb begin
        pc_next          = pc_o;
        if_id_instr_next = if_id_instr_o;
        if_id_pc_next    = if_id_pc_o;
        id_ex_ctrl_next  = id_ex_ctrl_o;

        if (act != ACT_FREEZE) begin
            id_ex_ctrl_next = bubble ? '0 : ctrl_i;
        end

        unique case (act)
            ACT_FREEZE: begin
            end
            ACT_LOAD_USE: begin
                if (pcwrite_i) begin
                    pc_next = pc_o + PC_STEP;
                end
            end
            ACT_REDIRECT: begin
                pc_next          = branch_target_i;
                if_id_instr_next = NOP_INSTR;
                if_id_pc_next    = pc_o;
            end
            ACT_ADVANCE: begin
                pc_next          = pc_o + PC_STEP;
                if_id_instr_next = instr_i;
                if_id_pc_next    = pc_o;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_o          <= RESET_PC;
            if_id_instr_o <= NOP_INSTR;
            if_id_pc_o    <= '0;
            id_ex_ctrl_o  <= '0;
            stall_cnt_o   <= '0;
            flush_cnt_o   <= '0;
            cycle_cnt_o   <= '0;
        end else begin
            pc_o          <= pc_next;
            if_id_instr_o <= if_id_instr_next;
            if_id_pc_o    <= if_id_pc_next;
            id_ex_ctrl_o  <= id_ex_ctrl_next;
            cycle_cnt_o   <= cycle_cnt_o + CNT_ONE;
            if (bubble) begin
                stall_cnt_o <= stall_cnt_o + CNT_ONE;
            end
            if (act == ACT_REDIRECT) begin
                flush_cnt_o <= flush_cnt_o + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_front_ctrl.sv
module tb_pipeline_front_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        stall_i = 1'b0;
    logic        noop_i = 1'b0;
    logic        pcwrite_i = 1'b1;
    logic        flush_i = 1'b0;
    logic [31:0] branch_target_i = '0;
    logic        mem_stall_i = 1'b0;
    logic [31:0] instr_i = '0;
    logic [7:0]  ctrl_i = '0;
    logic [31:0] pc_o, if_id_instr_o, if_id_pc_o;
    logic [7:0]  id_ex_ctrl_o;
    logic [31:0] stall_cnt_o, flush_cnt_o, cycle_cnt_o;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] iid;
        logic [31:0] ipc;
        logic [7:0]  ctrl;
        logic [31:0] sc;
        logic [31:0] fc;
        logic [31:0] cc;
    } exp_t;

    exp_t sb[$];
    exp_t m;

    pipeline_front_ctrl #(
        .RESET_PC (32'h0000_0000),
        .NOP_INSTR(NOP),
        .CTRL_W   (8),
        .CNT_W    (32)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .stall_i        (stall_i),
        .noop_i         (noop_i),
        .pcwrite_i      (pcwrite_i),
        .flush_i        (flush_i),
        .branch_target_i(branch_target_i),
        .mem_stall_i    (mem_stall_i),
        .instr_i        (instr_i),
        .ctrl_i         (ctrl_i),
        .pc_o           (pc_o),
        .if_id_instr_o  (if_id_instr_o),
        .if_id_pc_o     (if_id_pc_o),
        .id_ex_ctrl_o   (id_ex_ctrl_o),
        .stall_cnt_o    (stall_cnt_o),
        .flush_cnt_o    (flush_cnt_o),
        .cycle_cnt_o    (cycle_cnt_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    // Reference model: applies one edge of the priority rules to m.
    task automatic model_edge();
        logic [31:0] old_pc;
        old_pc = m.pc;
        if (rst_i) begin
            m = '{32'h0, NOP, 32'h0, 8'h0, 32'h0, 32'h0, 32'h0};
        end else begin
            m.cc = m.cc + 1;
            if (!mem_stall_i) begin
                if (noop_i) begin
                    m.ctrl = 8'h00;
                    m.sc   = m.sc + 1;
                end else begin
                    m.ctrl = ctrl_i;
                end
                if (stall_i) begin
                    if (pcwrite_i) m.pc = old_pc + 32'd4;
                end else if (flush_i) begin
                    m.pc  = branch_target_i;
                    m.iid = NOP;
                    m.ipc = old_pc;
                    m.fc  = m.fc + 1;
                end else begin
                    m.pc  = old_pc + 32'd4;
                    m.iid = instr_i;
                    m.ipc = old_pc;
                end
            end
        end
    endtask

    // One clock edge: predict, push, then pop and compare after the edge.
    task automatic tick();
        exp_t e;
        model_edge();
        sb.push_back(m);
        @(posedge clk);
        #1;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty got=0 entries want>=1");
        end else begin
            e = sb.pop_front();
            if (pc_o !== e.pc) begin
                failures++;
                $display("FAIL pc got=%h want=%h t=%0t", pc_o, e.pc, $time);
            end
            checks++;
            if (if_id_instr_o !== e.iid) begin
                failures++;
                $display("FAIL if_id_instr got=%h want=%h t=%0t", if_id_instr_o, e.iid, $time);
            end
            checks++;
            if (if_id_pc_o !== e.ipc) begin
                failures++;
                $display("FAIL if_id_pc got=%h want=%h t=%0t", if_id_pc_o, e.ipc, $time);
            end
            checks++;
            if (id_ex_ctrl_o !== e.ctrl) begin
                failures++;
                $display("FAIL id_ex_ctrl got=%h want=%h t=%0t", id_ex_ctrl_o, e.ctrl, $time);
            end
            checks++;
            if (stall_cnt_o !== e.sc) begin
                failures++;
                $display("FAIL stall_cnt got=%0d want=%0d t=%0t", stall_cnt_o, e.sc, $time);
            end
            checks++;
            if (flush_cnt_o !== e.fc) begin
                failures++;
                $display("FAIL flush_cnt got=%0d want=%0d t=%0t", flush_cnt_o, e.fc, $time);
            end
            checks++;
            if (cycle_cnt_o !== e.cc) begin
                failures++;
                $display("FAIL cycle_cnt got=%0d want=%0d t=%0t", cycle_cnt_o, e.cc, $time);
            end
        end
    endtask

    task automatic idle_inputs();
        rst_i = 1'b0; stall_i = 1'b0; noop_i = 1'b0; pcwrite_i = 1'b1;
        flush_i = 1'b0; mem_stall_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; flush_i = 1'b1; mem_stall_i = 1'b1; stall_i = 1'b1;
        branch_target_i = 32'h1234; ctrl_i = 8'hFF;
        tick();
        checks++;
        if (pc_o !== 32'h0 || if_id_instr_o !== NOP || cycle_cnt_o !== 32'h0) begin
            failures++;
            $display("FAIL reset_state got pc=%h instr=%h cyc=%0d want pc=0 instr=%h cyc=0",
                     pc_o, if_id_instr_o, cycle_cnt_o, NOP);
        end
        idle_inputs();
    endtask

    task automatic test_free_run();
        instr_i = 32'h00A0_0093; ctrl_i = 8'h11;
        repeat (3) tick();
        checks++;
        if (pc_o !== 32'hC || if_id_pc_o !== 32'h8 || if_id_instr_o !== 32'h00A0_0093
            || cycle_cnt_o !== 32'd3) begin
            failures++;
            $display("FAIL free_run got pc=%h ipc=%h instr=%h cyc=%0d want pc=c ipc=8 instr=00a00093 cyc=3",
                     pc_o, if_id_pc_o, if_id_instr_o, cycle_cnt_o);
        end
    endtask

    task automatic test_load_use();
        stall_i = 1'b1; noop_i = 1'b1; pcwrite_i = 1'b0; ctrl_i = 8'h5A;
        instr_i = 32'hDEAD_BEEF;
        tick();
        checks++;
        if (pc_o !== 32'hC || id_ex_ctrl_o !== 8'h00 || stall_cnt_o !== 32'd1
            || if_id_instr_o !== 32'h00A0_0093) begin
            failures++;
            $display("FAIL load_use got pc=%h ctrl=%h sc=%0d instr=%h want pc=c ctrl=00 sc=1 instr=00a00093",
                     pc_o, id_ex_ctrl_o, stall_cnt_o, if_id_instr_o);
        end
        idle_inputs();
        tick();
        checks++;
        if (id_ex_ctrl_o !== 8'h5A || pc_o !== 32'h10) begin
            failures++;
            $display("FAIL load_use_release got ctrl=%h pc=%h want ctrl=5a pc=10", id_ex_ctrl_o, pc_o);
        end
        // pcwrite_i=1 during a stall advances PC while IF/ID holds
        stall_i = 1'b1; pcwrite_i = 1'b1;
        tick();
        idle_inputs();
    endtask

    task automatic test_flush();
        flush_i = 1'b1; branch_target_i = 32'h40; ctrl_i = 8'h77;
        tick();
        checks++;
        if (pc_o !== 32'h40 || if_id_instr_o !== NOP || if_id_pc_o !== 32'h14
            || flush_cnt_o !== 32'd1 || id_ex_ctrl_o !== 8'h77) begin
            failures++;
            $display("FAIL flush got pc=%h instr=%h ipc=%h fc=%0d ctrl=%h want pc=40 instr=13 ipc=14 fc=1 ctrl=77",
                     pc_o, if_id_instr_o, if_id_pc_o, flush_cnt_o, id_ex_ctrl_o);
        end
        idle_inputs();
        // stall wins over flush
        stall_i = 1'b1; noop_i = 1'b1; pcwrite_i = 1'b0; flush_i = 1'b1;
        branch_target_i = 32'h800;
        tick();
        checks++;
        if (pc_o !== 32'h40 || flush_cnt_o !== 32'd1 || id_ex_ctrl_o !== 8'h00) begin
            failures++;
            $display("FAIL stall_over_flush got pc=%h fc=%0d ctrl=%h want pc=40 fc=1 ctrl=00",
                     pc_o, flush_cnt_o, id_ex_ctrl_o);
        end
        idle_inputs();
        // noop without stall: bubble plus normal advance
        noop_i = 1'b1; ctrl_i = 8'hC3;
        tick();
        idle_inputs();
    endtask

    task automatic test_mem_stall();
        logic [31:0] sc0, cc0;
        sc0 = m.sc; cc0 = m.cc;
        stall_i = 1'b1; noop_i = 1'b1; mem_stall_i = 1'b1; flush_i = 1'b1;
        ctrl_i = 8'hEE; instr_i = 32'h1111_2222;
        repeat (4) tick();
        checks++;
        if (stall_cnt_o !== sc0 || cycle_cnt_o !== cc0 + 32'd4) begin
            failures++;
            $display("FAIL mem_stall_counters got sc=%0d cyc=%0d want sc=%0d cyc=%0d",
                     stall_cnt_o, cycle_cnt_o, sc0, cc0 + 32'd4);
        end
        mem_stall_i = 1'b0; flush_i = 1'b0; pcwrite_i = 1'b0;
        tick();
        checks++;
        if (stall_cnt_o !== sc0 + 32'd1 || id_ex_ctrl_o !== 8'h00) begin
            failures++;
            $display("FAIL mem_stall_release got sc=%0d ctrl=%h want sc=%0d ctrl=00",
                     stall_cnt_o, id_ex_ctrl_o, sc0 + 32'd1);
        end
        idle_inputs();
    endtask

    task automatic test_pc_wrap();
        flush_i = 1'b1; branch_target_i = 32'hFFFF_FFFC;
        tick();
        idle_inputs();
        tick();
        checks++;
        if (pc_o !== 32'h0 || if_id_pc_o !== 32'hFFFF_FFFC) begin
            failures++;
            $display("FAIL pc_wrap got pc=%h ipc=%h want pc=0 ipc=fffffffc", pc_o, if_id_pc_o);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            stall_i = 1'b1; noop_i = 1'b1; pcwrite_i = 1'b0; instr_i = $urandom;
            tick();
        end
        idle_inputs();
        for (int i = 0; i < 60; i++) begin
            rst_i           = ($urandom_range(0, 29) == 0);
            stall_i         = ($urandom_range(0, 3) == 0);
            noop_i          = stall_i ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
            pcwrite_i       = $urandom_range(0, 1);
            flush_i         = ($urandom_range(0, 3) == 0);
            mem_stall_i     = ($urandom_range(0, 4) == 0);
            branch_target_i = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            instr_i         = $urandom;
            ctrl_i          = 8'($urandom);
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_flush();
        flush_i = 1'b1; mem_stall_i = 1'b1; branch_target_i = 32'h200;
        tick();
        rst_i = 1'b1;
        tick();
        checks++;
        if (pc_o !== 32'h0 || if_id_instr_o !== NOP || if_id_pc_o !== 32'h0
            || stall_cnt_o !== 32'h0 || flush_cnt_o !== 32'h0 || cycle_cnt_o !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid_flush got pc=%h instr=%h sc=%0d fc=%0d cyc=%0d want all reset",
                     pc_o, if_id_instr_o, stall_cnt_o, flush_cnt_o, cycle_cnt_o);
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        m = '{32'h0, NOP, 32'h0, 8'h0, 32'h0, 32'h0, 32'h0};
        @(negedge clk);
        test_reset();
        test_free_run();
        test_load_use();
        test_flush();
        test_mem_stall();
        test_pc_wrap();
        test_back_to_back();
        test_reset_mid_flush();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
